// File: rtl/mem_pkg.sv
// Shared types and helpers for the multi-channel byte-serial memory arbiter.
package mem_pkg;

  localparam logic [1:0]  SIZE_1B  = 2'd0;
  localparam logic [1:0]  SIZE_2B  = 2'd1;
  localparam logic [1:0]  SIZE_4B  = 2'd2;
  localparam logic [31:0] IO_MASK  = 32'h0003_0000;
  localparam logic [31:0] IO_MATCH = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_GAP
  } state_e;

  // Size code 3 is treated as a 4-byte access.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SIZE_1B: return 3'd1;
      SIZE_2B: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return (addr & IO_MASK) == IO_MATCH;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    return w[8*k +: 8];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IW-1:0]     idx_o
);

  logic found;
  int   c;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (int'(ptr_i) + i) % NUM_CH;
      if (!found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and byte-serial sequencer between NUM_CH requesters and the 8-bit memory/UART bus.
// state | meaning
// IDLE  | bus idle; arbitrates unless a done pulse is being shown
// READ  | issuing read addresses, capturing one byte per cycle
// WRITE | issuing write bytes
// GAP   | idle cycles forced after an IO-space write
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IO_GAP = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rdy_i,
  input  logic [7:0]           mem_din_i,
  output logic [7:0]           mem_dout_o,
  output logic [31:0]          mem_a_o,
  output logic                 mem_wr_o,
  input  logic                 io_buffer_full_i,
  input  logic                 clr_i,
  input  logic [NUM_CH-1:0]    ch_req_i,
  input  logic [NUM_CH-1:0]    ch_wr_i,
  input  logic [NUM_CH*32-1:0] ch_addr_i,
  input  logic [NUM_CH*2-1:0]  ch_size_i,
  input  logic [NUM_CH*32-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]    ch_done_o,
  output logic [31:0]          ch_rdata_o
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GW = (IO_GAP > 0) ? $clog2(IO_GAP + 1) : 1;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, ch_q, ch_d;
  logic [1:0]         cnt_q, cnt_d, last_q, last_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               io_q, io_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        mem_a_q, mem_a_d;
  logic [7:0]         mem_dout_q, mem_dout_d;
  logic               mem_wr_q, mem_wr_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [NUM_CH-1:0]  elig, grant;
  logic [IW-1:0]      win;
  logic [31:0]        win_addr, win_wdata;
  logic [1:0]         win_size;
  logic               win_wr;
  logic [2:0]         win_n;

  // An IO write is held back while the UART buffer is full; checked only at grant.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_req_i[i] &
                ~(ch_wr_i[i] & is_io(ch_addr_i[32*i +: 32]) & io_buffer_full_i);
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_rr (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win)
  );

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_size  = '0;
    win_wr    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == IW'(i)) begin
        win_addr  = ch_addr_i[32*i +: 32];
        win_wdata = ch_wdata_i[32*i +: 32];
        win_size  = ch_size_i[2*i +: 2];
        win_wr    = ch_wr_i[i];
      end
    end
    win_n = size_bytes(win_size);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gap_d      = gap_q;
    io_d       = io_q;
    wdata_d    = wdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    done_d     = done_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = '0;
        done_d     = '0;
        // The cycle showing done is not an arbitration cycle, so the requester can react first.
        if (done_q == '0 && !clr_i && |grant) begin
          ch_d       = win;
          ptr_d      = (int'(win) == NUM_CH - 1) ? '0 : win + IW'(1);
          cnt_d      = '0;
          last_d     = 2'(win_n - 3'd1);
          io_d       = win_wr & is_io(win_addr);
          wdata_d    = win_wdata;
          rdata_d    = '0;
          mem_a_d    = win_addr;
          mem_wr_d   = win_wr;
          mem_dout_d = win_wr ? win_wdata[7:0] : 8'h00;
          state_d    = win_wr ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (clr_i) begin
          mem_a_d = '0;
          rdata_d = '0;
          state_d = ST_IDLE;
        end else begin
          rdata_d[8*cnt_q +: 8] = mem_din_i;
          if (cnt_q == last_q) begin
            done_d       = '0;
            done_d[ch_q] = 1'b1;
            mem_a_d      = '0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            mem_a_d = mem_a_q + 32'd1;
          end
        end
      end
      ST_WRITE: begin
        if (cnt_q == last_q) begin
          done_d       = '0;
          done_d[ch_q] = 1'b1;
          mem_a_d      = '0;
          mem_wr_d     = 1'b0;
          mem_dout_d   = '0;
          gap_d        = GW'(IO_GAP);
          state_d      = io_q ? ST_GAP : ST_IDLE;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_a_d    = mem_a_q + 32'd1;
          mem_dout_d = byte_sel(wdata_q, cnt_q + 2'd1);
        end
      end
      ST_GAP: begin
        done_d = '0;
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      ch_q       <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      gap_q      <= '0;
      io_q       <= 1'b0;
      wdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      done_q     <= '0;
      rdata_q    <= '0;
    end else if (rdy_i) begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      io_q       <= io_d;
      wdata_q    <= wdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mem_a_o    = mem_a_q;
  assign mem_dout_o = mem_dout_q;
  assign mem_wr_o   = mem_wr_q;
  assign ch_done_o  = done_q;
  assign ch_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, round robin, UART back-pressure, clr, rdy, reset.
module tb_mem_arbiter;

  localparam int NUM_CH = 2;
  localparam int IO_GAP = 1;

  logic                 clk = 1'b0;
  logic                 rst_n, rdy, clr, io_full;
  logic [7:0]           mem_din, mem_dout;
  logic [31:0]          mem_a, ch_rdata;
  logic                 mem_wr;
  logic [NUM_CH-1:0]    ch_req, ch_wr, ch_done;
  logic [NUM_CH*32-1:0] ch_addr, ch_wdata;
  logic [NUM_CH*2-1:0]  ch_size;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CH(NUM_CH), .IO_GAP(IO_GAP)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .rdy_i            (rdy),
    .mem_din_i        (mem_din),
    .mem_dout_o       (mem_dout),
    .mem_a_o          (mem_a),
    .mem_wr_o         (mem_wr),
    .io_buffer_full_i (io_full),
    .clr_i            (clr),
    .ch_req_i         (ch_req),
    .ch_wr_i          (ch_wr),
    .ch_addr_i        (ch_addr),
    .ch_size_i        (ch_size),
    .ch_wdata_i       (ch_wdata),
    .ch_done_o        (ch_done),
    .ch_rdata_o       (ch_rdata)
  );

  // Memory returns the byte for the address currently on the bus.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  assign mem_din = mem_byte(mem_a);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ch(input int i, input logic req, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata);
    ch_req[i]           = req;
    ch_wr[i]            = wr;
    ch_addr[32*i +: 32]  = addr;
    ch_size[2*i +: 2]    = size;
    ch_wdata[32*i +: 32] = wdata;
  endtask

  logic [1:0] seq [4];
  int         nd, nwr, nbad;
  logic [1:0] got_done;

  initial begin
    rst_n = 1'b0; rdy = 1'b1; clr = 1'b0; io_full = 1'b0;
    ch_req = '0; ch_wr = '0; ch_addr = '0; ch_size = '0; ch_wdata = '0;
    repeat (3) tick();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_done", {30'h0, ch_done}, 32'h0);
    chk("rst_rdata", ch_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // 4-byte read on ch0
    set_ch(0, 1'b1, 1'b0, 32'h100, 2'd2, 32'h0);
    tick(); chk("rd4_a0", mem_a, 32'h100); chk("rd4_wr", {31'h0, mem_wr}, 32'h0);
    tick(); chk("rd4_a1", mem_a, 32'h101);
    tick(); chk("rd4_a2", mem_a, 32'h102);
    tick(); chk("rd4_a3", mem_a, 32'h103); chk("rd4_nodone", {30'h0, ch_done}, 32'h0);
    tick(); chk("rd4_done", {30'h0, ch_done}, 32'h1); chk("rd4_data", ch_rdata, 32'h44332211);
    chk("rd4_a_idle", mem_a, 32'h0);
    set_ch(0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    tick();

    // Both channels hammer; pointer is at ch1 after the ch0 grant
    set_ch(0, 1'b1, 1'b0, 32'h300, 2'd0, 32'h0);
    set_ch(1, 1'b1, 1'b1, 32'h200, 2'd0, 32'h0000_00AB);
    nd = 0; nwr = 0;
    for (int cyc = 0; cyc < 40 && nd < 4; cyc++) begin
      tick();
      if (mem_wr) begin
        nwr++;
        if (nwr == 1) begin
          chk("rr_wr_a", mem_a, 32'h200);
          chk("rr_wr_dout", {24'h0, mem_dout}, 32'hAB);
        end
      end
      if (ch_done != '0) begin
        seq[nd] = ch_done;
        if (nd == 1) chk("rr_rd_data", ch_rdata, 32'h5A);
        nd++;
      end
    end
    chk("rr_ndone", nd, 4);
    chk("rr_g0", {30'h0, seq[0]}, 32'h2);
    chk("rr_g1", {30'h0, seq[1]}, 32'h1);
    chk("rr_g2", {30'h0, seq[2]}, 32'h2);
    chk("rr_g3", {30'h0, seq[3]}, 32'h1);
    chk("rr_nwr", nwr, 2);
    ch_req = '0;
    tick();

    // UART full blocks the IO write; ch0 goes first
    io_full = 1'b1;
    set_ch(1, 1'b1, 1'b1, 32'h0003_0000, 2'd0, 32'h0000_005C);
    set_ch(0, 1'b1, 1'b0, 32'h300, 2'd0, 32'h0);
    got_done = '0; nbad = 0;
    for (int cyc = 0; cyc < 10 && got_done == '0; cyc++) begin
      tick();
      if (mem_wr) nbad++;
      got_done = ch_done;
    end
    chk("uart_first", {30'h0, got_done}, 32'h1);
    ch_req[0] = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (mem_wr || ch_done != '0) nbad++;
    end
    chk("uart_blocked", nbad, 0);
    io_full = 1'b0;
    tick(); chk("uart_wr", {31'h0, mem_wr}, 32'h1); chk("uart_a", mem_a, 32'h0003_0000);
    chk("uart_dout", {24'h0, mem_dout}, 32'h5C);
    tick(); chk("uart_done", {30'h0, ch_done}, 32'h2);
    set_ch(1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    set_ch(0, 1'b1, 1'b0, 32'h400, 2'd0, 32'h0);
    tick(); chk("gap_a0", mem_a, 32'h0);
    tick(); chk("gap_a1", mem_a, 32'h0);
    tick(); chk("gap_next", mem_a, 32'h400);
    tick(); chk("gap_done", {30'h0, ch_done}, 32'h1); chk("gap_data", ch_rdata, 32'h5A);
    ch_req = '0;
    tick();

    // clr aborts a read
    set_ch(0, 1'b1, 1'b0, 32'h100, 2'd2, 32'h0);
    tick(); chk("clr_a0", mem_a, 32'h100);
    tick(); chk("clr_a1", mem_a, 32'h101); clr = 1'b1;
    tick(); chk("clr_a_zero", mem_a, 32'h0); chk("clr_nodone", {30'h0, ch_done}, 32'h0);
    chk("clr_rdata", ch_rdata, 32'h0);
    clr = 1'b0; ch_req = '0;
    tick(); chk("clr_nodone2", {30'h0, ch_done}, 32'h0);

    // clr ignored during a 2-byte write
    set_ch(1, 1'b1, 1'b1, 32'h200, 2'd1, 32'h0000_BEEF);
    tick(); chk("clrw_wr0", {31'h0, mem_wr}, 32'h1); chk("clrw_b0", {24'h0, mem_dout}, 32'hEF);
    clr = 1'b1;
    tick(); chk("clrw_a1", mem_a, 32'h201); chk("clrw_b1", {24'h0, mem_dout}, 32'hBE);
    chk("clrw_wr1", {31'h0, mem_wr}, 32'h1);
    tick(); chk("clrw_done", {30'h0, ch_done}, 32'h2); chk("clrw_wr_off", {31'h0, mem_wr}, 32'h0);
    clr = 1'b0; ch_req = '0;
    tick();

    // rdy low for three cycles mid-read
    set_ch(0, 1'b1, 1'b0, 32'h100, 2'd2, 32'h0);
    tick();
    tick(); chk("rdy_a1", mem_a, 32'h101); rdy = 1'b0;
    tick(); chk("rdy_hold0", mem_a, 32'h101);
    tick();
    tick(); chk("rdy_hold2", mem_a, 32'h101); rdy = 1'b1;
    tick(); chk("rdy_a2", mem_a, 32'h102);
    tick(); chk("rdy_nodone", {30'h0, ch_done}, 32'h0);
    tick(); chk("rdy_done", {30'h0, ch_done}, 32'h1); chk("rdy_data", ch_rdata, 32'h44332211);
    ch_req = '0;
    tick();

    // Reset mid-write; pointer returns to ch0
    set_ch(0, 1'b1, 1'b0, 32'h300, 2'd0, 32'h0);
    set_ch(1, 1'b1, 1'b1, 32'h200, 2'd2, 32'h1234_5678);
    tick(); chk("rstw_a", mem_a, 32'h200); chk("rstw_b0", {24'h0, mem_dout}, 32'h78);
    tick(); rst_n = 1'b0;
    tick(); chk("rstw_wr", {31'h0, mem_wr}, 32'h0); chk("rstw_a0", mem_a, 32'h0);
    chk("rstw_dout", {24'h0, mem_dout}, 32'h0); chk("rstw_done", {30'h0, ch_done}, 32'h0);
    rst_n = 1'b1;
    tick(); chk("rstw_regrant", mem_a, 32'h300); chk("rstw_regrant_wr", {31'h0, mem_wr}, 32'h0);
    tick(); chk("rstw_done0", {30'h0, ch_done}, 32'h1);
    ch_req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
